pe_operand_sequencer: RTL and testbench
=======================================

# pe_operand_sequencer

Upstream feeder for the floating-point multiply-accumulate processingElement. It accepts one K×K pixel window and one K×K weight set per transaction and streams the pairs into the PE as floatA/floatB, one pair per cycle. It holds the PE accumulator cleared between windows, then captures the finished sum and presents it downstream on a valid/ready handshake. One instance sits in front of each PE in the convolution units.

## Interface
Parameters:
- KERNEL, 3, kernel side; N = KERNEL*KERNEL pairs per window
- DATA_WIDTH, 32, IEEE-754 single-precision word width
- PE_LATENCY, 1, edges from the PE sampling an operand pair until pe_result includes that product (≥1)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- in_valid  in  1  window/weights present
- in_ready  out  1  block can accept a window
- window  in  N*DATA_WIDTH  pixels; element i at [i*DATA_WIDTH +: DATA_WIDTH], row-major, i=0 streamed first
- weights  in  N*DATA_WIDTH  kernel weights, same packing
- pe_floatA  out  DATA_WIDTH  pixel operand to PE (registered)
- pe_floatB  out  DATA_WIDTH  weight operand to PE (registered)
- pe_reset  out  1  active-high clear to the PE accumulator (registered)
- pe_result  in  DATA_WIDTH  PE accumulator output
- out_valid  out  1  out_data holds a finished sum
- out_ready  in  1  downstream accepts out_data
- out_data  out  DATA_WIDTH  captured convolution sum (registered)

## Operation
- States: IDLE, STREAM, DRAIN, HOLD.
- Reset (reset=0): state IDLE, idx=0, drain count=0, pe_floatA=pe_floatB=0, pe_reset=1, out_valid=0, out_data=0.
- IDLE: in_ready=1, pe_reset=1, operands 0. On in_valid&in_ready: latch window and weights into local registers, then go to STREAM with idx=0.
- STREAM: pe_reset=0. At each cycle, pe_floatA/pe_floatB = latched element idx, and idx increments. After the element at idx N-1 has been presented, go to DRAIN.
- DRAIN: operands = +0.0 (32'h0000_0000), so extra PE accumulations are harmless. Count PE_LATENCY cycles. At the last cycle's edge, capture pe_result into out_data, set out_valid=1, and go to HOLD.
- HOLD: out_valid=1, out_data stable, pe_reset=1, operands 0. On out_ready, clear out_valid and go to IDLE.
- in_ready=0 in STREAM, DRAIN and HOLD. in_valid is ignored outside IDLE; upstream holds its data.
- No arithmetic is done in this block; words pass through bit-exact. idx is a counter of $clog2(N) bits and never wraps past N-1.
- Reset asserted mid-transaction: the window is discarded, no out_valid is produced, and pe_reset=1 takes effect immediately.

## Timing
- Accept edge E0: the pair for idx i is on the PE inputs during cycle E_i..E_(i+1), and the PE samples it at E_(i+1).
- STREAM→DRAIN at E_N. Capture and out_valid rise at E_(N+PE_LATENCY).
- Defaults (N=9, L=1): out_valid rises at E10.
- Earliest next accept is the cycle after the out_ready handshake edge. Minimum period is N+PE_LATENCY+2 cycles.
- A zero-wait out_ready (held high) is legal: out_valid is high for exactly one cycle.
- in_ready is combinational from state only, with no path from in_valid.

## Structure
- Shared package cnn_pkg holds:
  - FLOAT_ZERO = 32'h0000_0000
  - the default KERNEL
  - the state enum (IDLE, STREAM, DRAIN, HOLD)
- Single flat module. No sub-module is warranted; the operand mux is an indexed part-select of the latched vectors.

## Test plan
- Bench uses a behavioural PE model: clear on pe_reset, else acc += A*B with latency PE_LATENCY.
- Window all 2.0 (0x40000000), weights all 3.0 (0x40400000), accept at E0, out_ready=1 → out_valid at E10 for one cycle, out_data=0x42580000 (54.0); then in_ready returns high.
- Window element i = float(i), weights one-hot 1.0 (0x3F800000) at idx 4 → out_data=0x40800000 (4.0). Check the operand sequence 0..8 on pe_floatA in order.
- out_ready held low for 5 cycles after out_valid → out_data and out_valid stable, in_ready=0, in_valid pulses ignored. Release → IDLE the next cycle.
- reset driven low at idx 4 → pe_reset=1 and out_valid=0 asynchronously. A fresh window after release produces the correct sum with no residue from the aborted one.
- PE_LATENCY=3, all-2.0 × all-3.0 → out_valid rises at E12, out_data=0x42580000.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and the operand-sequencer state encoding used by the convolution units.
package cnn_pkg;
   localparam int          KERNEL_DEFAULT = 3;
   localparam logic [31:0] FLOAT_ZERO     = 32'h0000_0000;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, HOLD} seq_state_t;
endpackage

// File: rtl/pe_operand_sequencer.sv
// Streams one KxK window/weight pair per cycle into a MAC PE; out_valid rises N+PE_LATENCY edges after accept.
// Accepts a window only when idle; holds the captured sum until out_ready, stalling upstream meanwhile.
module pe_operand_sequencer
   import cnn_pkg::*;
#(
   parameter int KERNEL     = KERNEL_DEFAULT,
   parameter int DATA_WIDTH = 32,
   parameter int PE_LATENCY = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  window,
   input  logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  weights,
   output logic [DATA_WIDTH-1:0]                pe_floatA,
   output logic [DATA_WIDTH-1:0]                pe_floatB,
   output logic                                 pe_reset,
   input  logic [DATA_WIDTH-1:0]                pe_result,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [DATA_WIDTH-1:0]                out_data
);
   localparam int N  = KERNEL * KERNEL;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
   localparam logic [IW-1:0]         IDX_LAST = IW'(N - 1);
   localparam logic [CW-1:0]         CNT_LAST = CW'(PE_LATENCY - 1);
   localparam logic [DATA_WIDTH-1:0] OP_ZERO  = DATA_WIDTH'(FLOAT_ZERO);

   seq_state_t                  state;
   logic [IW-1:0]               idx;
   logic [IW-1:0]               idx_nxt;
   logic [CW-1:0]               cnt;
   logic [N*DATA_WIDTH-1:0]     win_q;
   logic [N*DATA_WIDTH-1:0]     wts_q;

   assign in_ready = (state == IDLE);
   assign idx_nxt  = idx + IW'(1);

   // Element 0 is taken straight from the inputs on the accept edge so the PE sees it during E0..E1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         win_q     <= '0;
         wts_q     <= '0;
         pe_floatA <= OP_ZERO;
         pe_floatB <= OP_ZERO;
         pe_reset  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  win_q     <= window;
                  wts_q     <= weights;
                  pe_floatA <= window[DATA_WIDTH-1:0];
                  pe_floatB <= weights[DATA_WIDTH-1:0];
                  pe_reset  <= 1'b0;
                  idx       <= '0;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               if (idx == IDX_LAST) begin
                  pe_floatA <= OP_ZERO;
                  pe_floatB <= OP_ZERO;
                  cnt       <= '0;
                  state     <= DRAIN;
               end else begin
                  idx       <= idx_nxt;
                  pe_floatA <= win_q[int'(idx_nxt)*DATA_WIDTH +: DATA_WIDTH];
                  pe_floatB <= wts_q[int'(idx_nxt)*DATA_WIDTH +: DATA_WIDTH];
               end
            end
            DRAIN: begin
               // Zero operands keep the accumulator unchanged while the PE pipeline empties.
               if (cnt == CNT_LAST) begin
                  out_data  <= pe_result;
                  out_valid <= 1'b1;
                  pe_reset  <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Drives a PE_LATENCY=1 and a PE_LATENCY=3 sequencer in lockstep, each feeding a behavioural MAC PE.
module tb_pe_operand_sequencer;
   localparam int K  = 3;
   localparam int N  = K * K;
   localparam int DW = 32;
   localparam int NL = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            in_valid  = 1'b0;
   logic            out_ready = 1'b1;
   logic [N*DW-1:0] window    = '0;
   logic [N*DW-1:0] weights   = '0;
   logic            ir [NL];
   logic            pr [NL];
   logic            ov [NL];
   logic [DW-1:0]   pa [NL];
   logic [DW-1:0]   pb [NL];
   logic [DW-1:0]   od [NL];
   logic [DW-1:0]   pres [NL];

   int checks = 0;
   int errors = 0;

   // float(i) for i = 0..8
   logic [31:0] fl [N] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                           32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) return 0.0;
      d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
   endfunction

   function automatic logic [31:0] dot(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
      real s;
      s = 0.0;
      for (int i = 0; i < N; i++) s = s + f2r(a[i*DW +: DW]) * f2r(b[i*DW +: DW]);
      return r2f(s);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < NL; g++) begin : lane
      localparam int L = (g == 0) ? 1 : 3;

      pe_operand_sequencer #(.KERNEL(K), .DATA_WIDTH(DW), .PE_LATENCY(L)) dut (
         .clk(clk), .reset(rst_n),
         .in_valid(in_valid), .in_ready(ir[g]),
         .window(window), .weights(weights),
         .pe_floatA(pa[g]), .pe_floatB(pb[g]), .pe_reset(pr[g]),
         .pe_result(pres[g]),
         .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g])
      );

      // Behavioural PE: accumulate on each edge, result visible L-1 edges later
      real           acc = 0.0;
      logic [DW-1:0] pipe [L];
      initial for (int k = 0; k < L; k++) pipe[k] = '0;
      always @(posedge clk) begin
         if (pr[g]) acc = 0.0;
         else       acc = acc + f2r(pa[g]) * f2r(pb[g]);
         pipe[0] <= r2f(acc);
         for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
      assign pres[g] = pipe[L-1];

      // Transaction model: ph 0 idle, 1 busy (t edges since accept), 2 holding the sum
      int              ph = 0;
      int              t  = 0;
      logic [N*DW-1:0] mw;
      logic [N*DW-1:0] mwt;
      logic [DW-1:0]   mdata;
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ph = 0; t = 0; mdata = '0;
         end else if (ph == 0) begin
            if (in_valid) begin ph = 1; t = 0; mw = window; mwt = weights; end
         end else if (ph == 1) begin
            t++;
            if (t == N + L) begin ph = 2; mdata = dot(mw, mwt); end
         end else if (out_ready) begin
            ph = 0;
         end
      end

      always @(negedge clk) begin
         logic [DW-1:0] ea, eb;
         ea = (ph == 1 && t < N) ? mw[t*DW +: DW]  : 32'h0;
         eb = (ph == 1 && t < N) ? mwt[t*DW +: DW] : 32'h0;
         chk($sformatf("lane%0d in_ready", g),  32'(ir[g]), 32'(ph == 0));
         chk($sformatf("lane%0d pe_reset", g),  32'(pr[g]), 32'(ph != 1));
         chk($sformatf("lane%0d out_valid", g), 32'(ov[g]), 32'(ph == 2));
         chk($sformatf("lane%0d pe_floatA", g), pa[g], ea);
         chk($sformatf("lane%0d pe_floatB", g), pb[g], eb);
         chk($sformatf("lane%0d out_data", g),  od[g], mdata);
      end
   end

   task automatic wait_ready();
      for (int k = 0; k < 60; k++) begin
         if (ir[0] && ir[1]) break;
         @(posedge clk); #1;
      end
      chk("both lanes ready", 32'(ir[0] & ir[1]), 32'd1);
   endtask

   // Returns at E0+1, E0 being the accept edge
   task automatic send(input logic [N*DW-1:0] w, input logic [N*DW-1:0] wt);
      wait_ready();
      window   = w;
      weights  = wt;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [N*DW-1:0] w2, w3, ramp, onehot, ones, junk;
      int r0, r1;
      for (int i = 0; i < N; i++) begin
         w2[i*DW +: DW]     = 32'h4000_0000;
         w3[i*DW +: DW]     = 32'h4040_0000;
         ramp[i*DW +: DW]   = fl[i];
         onehot[i*DW +: DW] = (i == 4) ? 32'h3F80_0000 : 32'h0;
         ones[i*DW +: DW]   = 32'h3F80_0000;
         junk[i*DW +: DW]   = 32'h4120_0000;
      end

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      for (int g = 0; g < NL; g++) begin
         chk("reset in_ready",  32'(ir[g]), 32'd1);
         chk("reset pe_reset",  32'(pr[g]), 32'd1);
         chk("reset out_valid", 32'(ov[g]), 32'd0);
         chk("reset out_data",  od[g], 32'h0);
         chk("reset pe_floatA", pa[g], 32'h0);
      end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // 2.0 x 3.0 over nine pairs, zero-wait out_ready
      send(w2, w3);
      r0 = -1; r1 = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (ov[0] && r0 < 0) r0 = k;
         if (ov[1] && r1 < 0) r1 = k;
         if (k == 11) chk("lane0 one-cycle out_valid", 32'(ov[0]), 32'd0);
      end
      chk("lane0 out_valid edge", r0, 32'd10);
      chk("lane1 out_valid edge", r1, 32'd12);
      chk("lane0 sum 54.0", od[0], 32'h4258_0000);
      chk("lane1 sum 54.0", od[1], 32'h4258_0000);
      chk("lane0 in_ready back", 32'(ir[0]), 32'd1);

      // Ramp window with one-hot weight at idx 4; check operand order
      send(ramp, onehot);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("operand A[%0d]", i), pa[0], fl[i]);
         @(posedge clk); #1;
      end
      wait_ready();
      chk("lane0 sum 4.0", od[0], 32'h4080_0000);
      chk("lane1 sum 4.0", od[1], 32'h4080_0000);

      // Backpressure: hold the result, ignore in_valid
      out_ready = 1'b0;
      send(w2, w3);
      for (int k = 0; k < 40; k++) begin
         if (ov[0] && ov[1]) break;
         @(posedge clk); #1;
      end
      for (int k = 0; k < 5; k++) begin
         window   = junk;
         in_valid = k[0];
         @(posedge clk); #1;
         for (int g = 0; g < NL; g++) begin
            chk("hold out_valid", 32'(ov[g]), 32'd1);
            chk("hold out_data",  od[g], 32'h4258_0000);
            chk("hold in_ready",  32'(ir[g]), 32'd0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release in_ready",  32'(ir[0]), 32'd1);
      chk("release out_valid", 32'(ov[0]), 32'd0);

      // Reset while idx 4 is on the PE inputs
      send(w2, w3);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int g = 0; g < NL; g++) begin
         chk("abort pe_reset",  32'(pr[g]), 32'd1);
         chk("abort out_valid", 32'(ov[g]), 32'd0);
         chk("abort pe_floatA", pa[g], 32'h0);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      send(ramp, ones);
      wait_ready();
      chk("lane0 post-abort sum 36.0", od[0], 32'h4210_0000);
      chk("lane1 post-abort sum 36.0", od[1], 32'h4210_0000);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
